// File: rtl/transaccion_pkg.sv
// Shared sizing constants, FSM encoding and helpers for the output-FIFO reader.
package transaccion_pkg;

   localparam int FIFO_WORD_SIZE = 10;
   localparam int NUM_PORTS      = 4;
   localparam int CNT_WIDTH      = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Port index of a one-hot (or zero) pop vector.
   function automatic logic [1:0] onehotToIdx(input logic [NUM_PORTS-1:0] v);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (v[i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester after the last grant.
module rr_arbiter
   import transaccion_pkg::*;
#(
   parameter int N = NUM_PORTS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] i_req,
   input  logic [N-1:0] i_mask,
   output logic [N-1:0] o_grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_cand;
   logic [PTR_W-1:0] w_gidx;
   logic [N-1:0]     w_elig;
   logic             w_found;

   assign w_elig = i_req & ~i_mask;

   // Search starts one past the last granted port and wraps around.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_cand  = '0;
      w_gidx  = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = PTR_W'((int'(r_ptr) + k) % N);
         if (!w_found && w_elig[w_cand]) begin
            o_grant[w_cand] = 1'b1;
            w_gidx          = w_cand;
            w_found         = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= PTR_W'(N - 1);
      end else if (w_found) begin
         r_ptr <= w_gidx;
      end
   end

endmodule

// File: rtl/lector_salidas.sv
// Drains the output FIFOs round-robin, presents each word two cycles after its pop,
// and keeps a saturating per-port word count readable on request.
module lector_salidas #(
   parameter int FIFO_WORD_SIZE = transaccion_pkg::FIFO_WORD_SIZE,
   parameter int NUM_PORTS      = transaccion_pkg::NUM_PORTS,
   parameter int CNT_WIDTH      = transaccion_pkg::CNT_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_PORTS-1:0]      fifo_empty,
   input  logic [FIFO_WORD_SIZE-1:0] data_in0,
   input  logic [FIFO_WORD_SIZE-1:0] data_in1,
   input  logic [FIFO_WORD_SIZE-1:0] data_in2,
   input  logic [FIFO_WORD_SIZE-1:0] data_in3,
   output logic [NUM_PORTS-1:0]      pop,
   output logic [FIFO_WORD_SIZE-1:0] word_out,
   output logic [1:0]                word_port,
   output logic                      word_valid,
   input  logic                      req,
   input  logic [1:0]                idx,
   output logic [CNT_WIDTH-1:0]      data,
   output logic                      valid
);

   import transaccion_pkg::*;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                    r_state;
   state_t                    w_nextState;
   logic [NUM_PORTS-1:0]      w_req;
   logic [NUM_PORTS-1:0]      w_grant;
   logic [NUM_PORTS-1:0]      r_pop;
   logic                      r_s1Valid;
   logic [1:0]                r_s1Port;
   logic [FIFO_WORD_SIZE-1:0] w_dataIn [4];
   logic [FIFO_WORD_SIZE-1:0] r_wordOut;
   logic [1:0]                r_wordPort;
   logic                      r_wordValid;
   logic [CNT_WIDTH-1:0]      r_cnt [NUM_PORTS];
   logic [CNT_WIDTH-1:0]      r_data;
   logic                      r_valid;

   assign w_dataIn[0] = data_in0;
   assign w_dataIn[1] = data_in1;
   assign w_dataIn[2] = data_in2;
   assign w_dataIn[3] = data_in3;

   always_comb begin
      w_nextState = r_state;
      w_req       = '0;
      case (r_state)
         IDLE: begin
            if (enable && !(&fifo_empty)) w_nextState = DRAIN;
         end
         DRAIN: begin
            if (!enable || (&fifo_empty)) w_nextState = IDLE;
            if (enable) w_req = ~fifo_empty;
         end
      endcase
   end

   // Masking with the current pop hides a port whose empty flag has not caught up yet.
   rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_req   (w_req),
      .i_mask  (r_pop),
      .o_grant (w_grant)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pop       <= '0;
         r_s1Valid   <= 1'b0;
         r_s1Port    <= '0;
         r_wordOut   <= '0;
         r_wordPort  <= '0;
         r_wordValid <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_pop       <= w_grant;
         r_s1Valid   <= |r_pop;
         r_s1Port    <= onehotToIdx(r_pop);
         r_wordValid <= r_s1Valid;
         r_wordOut   <= r_s1Valid ? w_dataIn[r_s1Port] : '0;
         r_wordPort  <= r_s1Valid ? r_s1Port : '0;
      end
   end

   // Readout samples the counters before this cycle's increment lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_wordValid && (r_wordPort == 2'(i)) && (r_cnt[i] != CNT_MAX)) begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
         r_valid <= req;
         r_data  <= req ? r_cnt[idx] : '0;
      end
   end

   assign pop        = r_pop;
   assign word_out   = r_wordOut;
   assign word_port  = r_wordPort;
   assign word_valid = r_wordValid;
   assign data       = r_data;
   assign valid      = r_valid;

endmodule
